// File: rtl/gps_iq_reader.sv
// Serial IQ snapshot reader: services correlator channel epochs round-robin,
// shifts each channel's accumulator snapshot out and queues framed 16-bit records for the CPU.
module gps_iq_reader #(
    parameter int NCH        = 12,
    parameter int INTEG_BITS = 20,
    parameter int FIFO_AW    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     epoch,
    input  logic [NCH-1:0]     sout,
    output logic [NCH-1:0]     shift,
    input  logic               rd_en,
    output logic [15:0]        rd_data,
    output logic               rd_empty,
    output logic [FIFO_AW:0]   rd_count,
    output logic [NCH-1:0]     ovf,
    input  logic               clr_ovf
);
    localparam int NBITS   = 6 * INTEG_BITS;
    localparam int NWORDS  = (NBITS + 15) / 16;
    localparam int REC_LEN = NWORDS + 1;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int REM     = NBITS % 16;
    localparam int PAD_SH  = 16 - REM;
    localparam int CNT_W   = (NBITS > 16) ? $clog2(NBITS) : 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);
    localparam logic [3:0]       RR_INIT  = 4'(NCH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAD, COMMIT} state_t;
    state_t state, state_nxt;

    logic [15:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, commit_ptr, rec_start, used;
    logic [NCH-1:0]   pending, cand, gnt_mask, cur_mask, ovf_set;
    logic [3:0]       rr_ptr, cur_ch, gnt_ch;
    logic [CNT_W-1:0] bit_cnt;
    logic [15:0]      word_sr, wr_word;
    logic             gnt_found, grant, fits, drop, abort, wr_en, commit, pop, sout_bit;
    int               idx;

    assign used     = wr_ptr - rd_ptr;
    assign fits     = (32'(used) + 32'(REC_LEN)) <= 32'(DEPTH);
    assign cur_mask = NCH'(1) << cur_ch;
    assign sout_bit = |(sout & cur_mask);
    assign abort    = ((state == SHIFT) || (state == PAD)) && |(epoch & cur_mask);
    // A channel pulsing epoch this very cycle reloads next cycle; serve it one cycle later.
    assign cand     = pending & ~epoch;
    assign grant    = (state == IDLE) && gnt_found;
    assign drop     = grant && !fits;
    assign gnt_mask = grant ? (NCH'(1) << gnt_ch) : '0;
    assign ovf_set  = (epoch & pending) | (drop ? gnt_mask : '0) | (abort ? cur_mask : '0);

    assign rd_empty = (commit_ptr == rd_ptr);
    assign rd_count = commit_ptr - rd_ptr;
    assign pop      = rd_en && !rd_empty;
    assign rd_data  = rd_empty ? 16'h0000 : mem[rd_ptr[FIFO_AW-1:0]];

    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx       = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(rr_ptr) + i) % NCH;
            if (!gnt_found && cand[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = 4'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift     = '0;
        wr_en     = 1'b0;
        wr_word   = '0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (grant && fits) begin
                    wr_en     = 1'b1;
                    wr_word   = {4'hA, 8'h00, gnt_ch};
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = cur_mask;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    if (bit_cnt[3:0] == 4'hF) begin
                        wr_en   = 1'b1;
                        wr_word = {word_sr[14:0], sout_bit};
                    end
                    if (bit_cnt == LAST_BIT) state_nxt = (REM != 0) ? PAD : COMMIT;
                end
            end
            PAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    // Only the last REM bits are fresh; shifting left drops stale ones and zero-fills.
                    wr_en     = 1'b1;
                    wr_word   = word_sr << PAD_SH;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            rr_ptr     <= RR_INIT;
            cur_ch     <= '0;
            bit_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            rec_start  <= '0;
            ovf        <= '0;
        end else begin
            pending <= (pending & ~gnt_mask) | epoch;
            if (grant) begin
                rr_ptr    <= gnt_ch;
                cur_ch    <= gnt_ch;
                rec_start <= wr_ptr;
                bit_cnt   <= '0;
            end
            if (state == SHIFT) bit_cnt <= bit_cnt + 1'b1;
            // An aborted record is discarded by rewinding to its header slot.
            if (abort)      wr_ptr <= rec_start;
            else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (commit) commit_ptr <= wr_ptr;
            if (pop)    rd_ptr     <= rd_ptr + 1'b1;
            ovf <= clr_ovf ? ovf_set : (ovf | ovf_set);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)           mem[wr_ptr[FIFO_AW-1:0]] <= wr_word;
        if (state == SHIFT)  word_sr <= {word_sr[14:0], sout_bit};
    end
endmodule
